// File: rtl/rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wport_arbiter
//
// Shares the register file's single write port between two writeback
// sources. Port 0 is the main pipeline writeback and normally wins. Port 1 is
// the multi-cycle unit (mult/div) result mover. It is guaranteed progress by a
// starvation counter that forces a port-1 grant after STARVE_MAX consecutive
// denials.
//
// The write-port stage is registered, so a write accepted in cycle N appears on
// rf_we/rf_a3/rf_wdata/rf_pc in cycle N+1. Writes to register $0 are accepted
// but never raise rf_we.
//
// Parameters
//   ADDR_W      register index width
//   DATA_W      write data width
//   STARVE_MAX  consecutive port-1 denials before a forced port-1 grant (1..15)
//
// Ports
//   clk, reset           clock (posedge) and synchronous active-high reset
//   p0_valid/p0_ready    port 0 handshake (pipeline writeback)
//   p0_addr/data/pc      port 0 payload: destination, value, trace address
//   p1_valid/p1_ready    port 1 handshake (multi-cycle unit writeback)
//   p1_addr/data/pc      port 1 payload
//   rf_we/a3/wdata/pc    registered register-file write port
//   starve_cnt           current count of consecutive port-1 denials (debug)
// ---------------------------------------------------------------------------
module rf_wport_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic [31:0]       p0_pc,

  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic [31:0]       p1_pc,

  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       rf_pc,
  output logic [3:0]        starve_cnt
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  // Arbitration signals shared by the ready outputs and the output stage.
  logic              force_p1;
  logic              grant0;
  logic              grant1;
  logic              xfer_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       sel_pc;

  // Port 0 wins unless port 1 has waited STARVE_MAX cycles in a row.
  // Reset masks both grants so nothing is accepted while the block is being
  // cleared. Requests still pending are simply re-arbitrated once reset drops.
  always_comb begin
    force_p1 = (starve_cnt == STARVE_LIMIT) && p1_valid;
    grant1   = !reset && p1_valid && (!p0_valid || force_p1);
    grant0   = !reset && p0_valid && !force_p1;
    p0_ready = grant0;
    p1_ready = grant1;
  end

  // Payload mux for the granted port. The grants are mutually exclusive, so
  // checking grant0 first just picks the one that is active.
  always_comb begin
    xfer_any = grant0 || grant1;
    sel_addr = p1_addr;
    sel_data = p1_data;
    sel_pc   = p1_pc;
    if (grant0) begin
      sel_addr = p0_addr;
      sel_data = p0_data;
      sel_pc   = p0_pc;
    end
  end

  // Registered write port. The address, data and trace pc hold their last
  // value when nothing transfers. This keeps the register file's inputs quiet
  // between writes. A transfer to $0 still loads the payload but leaves rf_we
  // low, so the hardwired zero register is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_a3    <= '0;
      rf_wdata <= '0;
      rf_pc    <= '0;
    end else if (xfer_any) begin
      rf_we    <= (sel_addr != '0);
      rf_a3    <= sel_addr;
      rf_wdata <= sel_data;
      rf_pc    <= sel_pc;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Starvation counter. It counts only while port 1 is actually waiting and
  // restarts whenever port 1 is served or withdraws its request. It saturates
  // at the limit. In practice the forced grant clears it on the very next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant1 || !p1_valid) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wport_arbiter
//
// Directed vector table for single-cycle behaviour, hand-written sequences
// for same-destination ordering and mid-stream reset, and a random
// valid/payload stress run checked against a small behavioural model.
// ---------------------------------------------------------------------------
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [4:0]  p0_addr, p1_addr;
  logic [31:0] p0_data, p1_data, p0_pc, p1_pc;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wdata, rf_pc;
  logic [3:0]  starve_cnt;

  int assert_count = 0;
  int fail_count   = 0;

  rf_wport_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr),
    .p0_data(p0_data), .p0_pc(p0_pc),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr),
    .p1_data(p1_data), .p1_pc(p1_pc),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
    .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // One directed vector: inputs for a cycle, the expected readies in that
  // cycle, and the expected registered outputs after the following edge.
  typedef struct {
    logic        p0v;
    logic [4:0]  p0a;
    logic [31:0] p0d;
    logic [31:0] p0pc;
    logic        p1v;
    logic [4:0]  p1a;
    logic [31:0] p1d;
    logic [31:0] p1pc;
    logic        er0;
    logic        er1;
    logic        ewe;
    logic [4:0]  ea3;
    logic [31:0] ewd;
    logic [31:0] epc;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    p0_valid = v.p0v; p0_addr = v.p0a; p0_data = v.p0d; p0_pc = v.p0pc;
    p1_valid = v.p1v; p1_addr = v.p1a; p1_data = v.p1d; p1_pc = v.p1pc;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state for the random stress run.
  logic [3:0]  cnt_m;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;
  logic        g0, g1, frc;

  initial begin
    reset = 1'b1;
    p0_valid = 1'b1; p1_valid = 1'b1;
    p0_addr = 5'd7; p0_data = 32'h1; p0_pc = 32'h10;
    p1_addr = 5'd6; p1_data = 32'h2; p1_pc = 32'h20;

    // Columns: p0 v/addr/data/pc, p1 v/addr/data/pc, ready0, ready1,
    // then we/a3/wdata/pc/starve_cnt after the edge.
    vecs[0]  = '{1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 4'd0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h3000, 4'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hFFFF, 32'h4000,
                 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF, 32'h4000, 4'd0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 32'h99, 32'h4004,
                 1'b0, 1'b1, 1'b1, 5'd9, 32'h99, 32'h4004, 4'd0};
    vecs[4]  = '{1'b1, 5'd1, 32'h11, 32'h100, 1'b1, 5'd2, 32'h22, 32'h200,
                 1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 32'h100, 4'd1};
    vecs[5]  = '{1'b1, 5'd1, 32'h11, 32'h100, 1'b1, 5'd2, 32'h22, 32'h200,
                 1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 32'h100, 4'd2};
    vecs[6]  = '{1'b1, 5'd1, 32'h11, 32'h100, 1'b1, 5'd2, 32'h22, 32'h200,
                 1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 32'h100, 4'd3};
    vecs[7]  = '{1'b1, 5'd1, 32'h11, 32'h100, 1'b1, 5'd2, 32'h22, 32'h200,
                 1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 32'h100, 4'd4};
    vecs[8]  = '{1'b1, 5'd1, 32'h11, 32'h100, 1'b1, 5'd2, 32'h22, 32'h200,
                 1'b0, 1'b1, 1'b1, 5'd2, 32'h22, 32'h200, 4'd0};
    vecs[9]  = '{1'b1, 5'd1, 32'h11, 32'h100, 1'b1, 5'd2, 32'h22, 32'h200,
                 1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 32'h100, 4'd1};
    vecs[10] = '{1'b1, 5'd0, 32'h77, 32'h108, 1'b0, 5'd0, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'h77, 32'h108, 4'd0};
    vecs[11] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 5'd0, 32'h77, 32'h108, 4'd0};

    // Reset with both ports requesting: nothing accepted, outputs cleared.
    stepCycle();
    checkOutput("reset_p0_ready", 32'(p0_ready), 32'd0);
    checkOutput("reset_p1_ready", 32'(p1_ready), 32'd0);
    checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
    checkOutput("reset_rf_a3", 32'(rf_a3), 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
    checkOutput("reset_rf_pc", rf_pc, 32'd0);
    checkOutput("reset_starve_cnt", 32'(starve_cnt), 32'd0);
    reset = 1'b0;
    p0_valid = 1'b0; p1_valid = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_p0_ready", i), 32'(p0_ready), 32'(vecs[i].er0));
      checkOutput($sformatf("v%0d_p1_ready", i), 32'(p1_ready), 32'(vecs[i].er1));
      stepCycle();
      checkOutput($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].ewe));
      checkOutput($sformatf("v%0d_rf_a3", i), 32'(rf_a3), 32'(vecs[i].ea3));
      checkOutput($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].ewd);
      checkOutput($sformatf("v%0d_rf_pc", i), rf_pc, vecs[i].epc);
      checkOutput($sformatf("v%0d_starve_cnt", i), 32'(starve_cnt), 32'(vecs[i].ecnt));
    end

    $display("[TB] reset while port 1 is starved");
    p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'h33; p0_pc = 32'h300;
    p1_valid = 1'b1; p1_addr = 5'd4; p1_data = 32'h44; p1_pc = 32'h400;
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("starve_pre_reset", 32'(starve_cnt), 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("midreset_p0_ready", 32'(p0_ready), 32'd0);
    checkOutput("midreset_p1_ready", 32'(p1_ready), 32'd0);
    stepCycle();
    checkOutput("midreset_starve_cnt", 32'(starve_cnt), 32'd0);
    checkOutput("midreset_rf_we", 32'(rf_we), 32'd0);
    checkOutput("midreset_rf_a3", 32'(rf_a3), 32'd0);
    checkOutput("midreset_rf_wdata", rf_wdata, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("postreset_p0_ready", 32'(p0_ready), 32'd1);
    checkOutput("postreset_p1_ready", 32'(p1_ready), 32'd0);
    stepCycle();
    checkOutput("postreset_rf_wdata", rf_wdata, 32'h33);
    checkOutput("postreset_starve_cnt", 32'(starve_cnt), 32'd1);

    $display("[TB] same destination on both ports");
    p0_valid = 1'b0; p1_valid = 1'b0;
    stepCycle();
    checkOutput("samedst_cnt_clear", 32'(starve_cnt), 32'd0);
    p0_valid = 1'b1; p0_addr = 5'd8; p0_data = 32'hA; p0_pc = 32'h500;
    p1_valid = 1'b1; p1_addr = 5'd8; p1_data = 32'hB; p1_pc = 32'h600;
    #1;
    checkOutput("samedst_c1_p0_ready", 32'(p0_ready), 32'd1);
    checkOutput("samedst_c1_p1_ready", 32'(p1_ready), 32'd0);
    stepCycle();
    checkOutput("samedst_c1_rf_wdata", rf_wdata, 32'hA);
    checkOutput("samedst_c1_rf_we", 32'(rf_we), 32'd1);
    p0_valid = 1'b0;
    #1;
    checkOutput("samedst_c2_p1_ready", 32'(p1_ready), 32'd1);
    stepCycle();
    checkOutput("samedst_c2_rf_wdata", rf_wdata, 32'hB);
    checkOutput("samedst_c2_rf_a3", 32'(rf_a3), 32'd8);
    checkOutput("samedst_c2_rf_we", 32'(rf_we), 32'd1);
    p1_valid = 1'b0;

    $display("[TB] random stress against model");
    cnt_m = 4'd0;
    m_a3 = rf_a3; m_wd = rf_wdata; m_pc = rf_pc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Requesters hold valid and payload until accepted.
      if (!p0_valid && ($urandom_range(0, 3) != 0)) begin
        p0_valid = 1'b1;
        p0_addr  = 5'($urandom_range(0, 31));
        p0_data  = $urandom;
        p0_pc    = $urandom;
      end
      if (!p1_valid && ($urandom_range(0, 2) == 0)) begin
        p1_valid = 1'b1;
        p1_addr  = 5'($urandom_range(0, 31));
        p1_data  = $urandom;
        p1_pc    = $urandom;
      end
      #1;
      frc = (cnt_m == 4'd4) && p1_valid;
      g1  = p1_valid && (!p0_valid || frc);
      g0  = p0_valid && !frc;
      checkOutput("stress_p0_ready", 32'(p0_ready), 32'(g0));
      checkOutput("stress_p1_ready", 32'(p1_ready), 32'(g1));
      checkOutput("stress_ready_exclusive", 32'(p0_ready && p1_ready), 32'd0);
      m_we = 1'b0;
      if (g0) begin
        m_we = (p0_addr != 5'd0); m_a3 = p0_addr; m_wd = p0_data; m_pc = p0_pc;
      end else if (g1) begin
        m_we = (p1_addr != 5'd0); m_a3 = p1_addr; m_wd = p1_data; m_pc = p1_pc;
      end
      if (g1 || !p1_valid) cnt_m = 4'd0;
      else if (cnt_m != 4'd4) cnt_m = cnt_m + 4'd1;
      stepCycle();
      checkOutput("stress_rf_we", 32'(rf_we), 32'(m_we));
      checkOutput("stress_starve_cnt", 32'(starve_cnt), 32'(cnt_m));
      if (m_we) begin
        checkOutput("stress_rf_a3", 32'(rf_a3), 32'(m_a3));
        checkOutput("stress_rf_wdata", rf_wdata, m_wd);
        checkOutput("stress_rf_pc", rf_pc, m_pc);
      end
      if (g0) p0_valid = 1'b0;
      if (g1) p1_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
